sd_sector_streamer: RTL
=======================

// Module: sd_sector_streamer
// PURPOSE
// - Sector-read front end of the fake-SD data path: turns a multi-block read request into sequential word reads
//   on the content ROM port (rdreq/rdaddr/rddata) and emits a byte stream with valid/ready to the DAT-line serializer.
// - Sector N occupies ROM words {N, 8'h00}..{N, 8'hFF}; bytes leave low byte first (word 16'haa55 -> 8'h55, 8'haa).
// PARAMETERS
// - ADDR_W      40  ROM word-address width; equals 32-bit sector number + WIDX_W
// - WIDX_W      8   log2(words per sector); 8 -> 256 words = 512 bytes
// - GAP_CYCLES  8   idle cycles inserted between consecutive blocks (min 1)
// PORTS
// - clk       in   1       single clock; also drives the ROM read port
// - rst       in   1       synchronous, active-high reset
// - start     in   1       request pulse; sampled only while busy=0
// - sector    in   32      first sector number, captured on accepted start
// - nblocks   in   16      block count, captured on accepted start; 0 treated as 1
// - abort     in   1       stop-transmission request; honoured at any time while busy
// - busy      out  1       high from accepted start until done
// - done      out  1       one-cycle pulse at end of transfer (normal or aborted)
// - rdreq     out  1       ROM read strobe
// - rdaddr    out  ADDR_W  ROM word address
// - rddata    in   16      ROM data, valid the cycle after rdreq
// - out_valid out  1       byte available
// - out_ready in   1       consumer accepts byte when out_valid & out_ready
// - out_data  out  8       byte
// - out_first out  1       qualifies first byte of a block
// - out_last  out  1       qualifies final byte of a block (last data byte, or last CRC byte with CRC16_EN)
// BEHAVIOUR
// - Reset: busy=0, done=0, rdreq=0, rdaddr=0, out_valid=0, out_data=0, out_first=0, out_last=0; FSM->IDLE; abort/start ignored.
// - FSM: IDLE -> STREAM on start; STREAM -> (CRC if CRC16_EN) -> GAP when last byte of block accepted;
//   GAP -> STREAM after GAP_CYCLES if blocks remain, else -> FIN; FIN pulses done, -> IDLE.
// - Latency: start sampled at edge 0 -> rdreq=1 with rdaddr={sector,0} after edge 1 -> out_valid=1 after edge 3.
// - Prefetch: 2-word buffer; next word requested while current word drains, so with out_ready held high
//   the stream is 1 byte/clock for all 512 bytes of a block; rdreq only issued when a buffer slot is guaranteed free.
// - Backpressure: while out_valid & !out_ready, out_data/out_first/out_last stay stable; no word is skipped or re-read.
// - Addressing: word index wraps 8'hFF->8'h00 and sector increments per block (32-bit, wraps FFFF_FFFF->0); rdaddr={sector,idx}.
// - Block count decremented on each block's final accepted byte; transfer ends when it reaches 0.
// - abort: takes effect the cycle it is sampled high: out_valid drops next cycle, pending ROM data discarded, rdreq=0,
//   FSM -> FIN (done pulses, busy falls). A byte accepted in the same cycle as abort counts as delivered.
// - start while busy=1 ignored; start and abort in the same IDLE cycle: start accepted, abort ignored.
// - done and busy fall in the same cycle; start may be accepted the cycle after done.
// CONFIGURATION
// - SD_SECTOR_CRC16_EN defined: after 512 data bytes, two extra bytes per block carrying CRC16-CCITT
//   (x^16+x^12+x^5+1, init 16'h0000, MSB-first bitwise over data bytes in stream order), high byte first;
//   out_last on second CRC byte. Undefined: no CRC state, out_last on data byte 512.
// TESTING
// - rst, start sector=0, nblocks=1, out_ready=1 -> 512 bytes in 512 consecutive cycles; bytes 510/511 = 8'h55/8'haa; done once.
// - start sector=32'h2000, nblocks=2 -> first bytes 8'heb,8'h00,8'h90,8'h20; rdaddr 40'h0000200000..2001ff; GAP_CYCLES gap between blocks.
// - out_ready toggled pseudo-randomly during sector 32'h4100 -> byte stream identical to out_ready=1 run ("Hello world!\r\n...").
// - abort asserted after 100 accepted bytes -> out_valid low next cycle, done pulse, busy=0, no further rdreq.
// - SD_SECTOR_CRC16_EN, sector 32'h0 all-zero except 55/aa tail -> 514 bytes, CRC bytes match golden CCITT model.
// - start held high through busy and nblocks=0 -> exactly one block transferred, second start only after done.

Source files
------------

// File: rtl/sd_sector_streamer.sv
// sd_sector_streamer: multi-block sector read into ROM word reads and a byte stream.
// Define SD_SECTOR_CRC16_EN to append a CRC16-CCITT trailer to every block.

module sd_sector_streamer #(
    parameter int ADDR_W     = 40,
    parameter int WIDX_W     = 8,
    parameter int GAP_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       sector,
    input  logic [15:0]       nblocks,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rdreq,
    output logic [ADDR_W-1:0] rdaddr,
    input  logic [15:0]       rddata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_first,
    output logic              out_last
);

    localparam int BCNT_W = WIDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
`ifdef SD_SECTOR_CRC16_EN
        S_CRC,
`endif
        S_GAP,
        S_FIN
    } state_t;

    state_t            st;
    logic [31:0]       rsec;
    logic [WIDX_W-1:0] ridx;
    logic              rq_done;
    logic              rvalid;
    logic [15:0]       wbuf0;
    logic [15:0]       wbuf1;
    logic [1:0]        cnt;
    logic              ph;
    logic [BCNT_W-1:0] bcnt;
    logic [15:0]       nblk;
    logic [15:0]       gcnt;
`ifdef SD_SECTOR_CRC16_EN
    logic [15:0]       crc;
    logic              csel;
`endif

    logic              acc;
    logic              pop;
    logic              issue;
    logic              blk_end;
    logic [1:0]        cnt_pop;
    logic [2:0]        occ;
    logic [7:0]        head_byte;

`ifdef SD_SECTOR_CRC16_EN
    function automatic logic [15:0] crc_byte(input logic [15:0] c,
                                             input logic [7:0]  d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction
`endif

    // Output decode, prefetch slot accounting and block-end detection.
    always_comb begin
        head_byte = ph ? wbuf0[15:8] : wbuf0[7:0];
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_first = 1'b0;
        out_last  = 1'b0;
        if (st == S_STREAM && cnt != 2'd0) begin
            out_valid = 1'b1;
            out_data  = head_byte;
            out_first = (bcnt == {BCNT_W{1'b0}});
`ifndef SD_SECTOR_CRC16_EN
            out_last  = (bcnt == {BCNT_W{1'b1}});
`endif
        end
`ifdef SD_SECTOR_CRC16_EN
        if (st == S_CRC) begin
            out_valid = 1'b1;
            out_data  = csel ? crc[7:0] : crc[15:8];
            out_last  = csel;
        end
`endif
        acc     = out_valid & out_ready;
        pop     = (st == S_STREAM) & acc & ph;
        cnt_pop = cnt - {1'b0, pop};
        occ     = {1'b0, cnt} + {2'b00, rdreq} + {2'b00, rvalid};
        issue   = (st == S_STREAM) & ~abort & ~rq_done &
                  ((occ - {2'b00, pop}) < 3'd2);
        blk_end = (st == S_STREAM) & acc & (bcnt == {BCNT_W{1'b1}});
    end

    // Transfer FSM with ROM request pipeline and two-word buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdreq   <= 1'b0;
            rdaddr  <= '0;
            rsec    <= '0;
            ridx    <= '0;
            rq_done <= 1'b0;
            rvalid  <= 1'b0;
            wbuf0   <= '0;
            wbuf1   <= '0;
            cnt     <= 2'd0;
            ph      <= 1'b0;
            bcnt    <= '0;
            nblk    <= '0;
            gcnt    <= '0;
`ifdef SD_SECTOR_CRC16_EN
            crc     <= '0;
            csel    <= 1'b0;
`endif
        end else begin
            done  <= 1'b0;
            rdreq <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        rsec    <= sector;
                        ridx    <= '0;
                        rq_done <= 1'b0;
                        nblk    <= (nblocks == 16'd0) ? 16'd1 : nblocks;
                        bcnt    <= '0;
                        ph      <= 1'b0;
                        cnt     <= 2'd0;
                        rvalid  <= 1'b0;
`ifdef SD_SECTOR_CRC16_EN
                        crc     <= '0;
`endif
                        st      <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (abort) begin
                        st     <= S_FIN;
                        done   <= 1'b1;
                        cnt    <= 2'd0;
                        rvalid <= 1'b0;
                    end else begin
                        rdreq  <= issue;
                        rvalid <= rdreq;
                        if (issue) begin
                            rdaddr <= ADDR_W'({rsec, ridx});
                            ridx   <= ridx + 1'b1;
                            if (ridx == {WIDX_W{1'b1}}) begin
                                rq_done <= 1'b1;
                                rsec    <= rsec + 32'd1;
                            end
                        end
                        if (pop) wbuf0 <= wbuf1;
                        if (rvalid) begin
                            if (cnt_pop == 2'd0) wbuf0 <= rddata;
                            else                 wbuf1 <= rddata;
                        end
                        cnt <= cnt_pop + {1'b0, rvalid};
                        if (acc) begin
                            ph   <= ~ph;
                            bcnt <= bcnt + 1'b1;
`ifdef SD_SECTOR_CRC16_EN
                            crc  <= crc_byte(crc, out_data);
`endif
                        end
                        if (blk_end) begin
`ifdef SD_SECTOR_CRC16_EN
                            st   <= S_CRC;
                            csel <= 1'b0;
`else
                            nblk <= nblk - 16'd1;
                            st   <= S_GAP;
                            gcnt <= '0;
`endif
                        end
                    end
                end
`ifdef SD_SECTOR_CRC16_EN
                S_CRC: begin
                    if (abort) begin
                        st   <= S_FIN;
                        done <= 1'b1;
                    end else if (acc) begin
                        if (csel) begin
                            nblk <= nblk - 16'd1;
                            st   <= S_GAP;
                            gcnt <= '0;
                        end else begin
                            csel <= 1'b1;
                        end
                    end
                end
`endif
                S_GAP: begin
                    if (abort) begin
                        st   <= S_FIN;
                        done <= 1'b1;
                    end else if (gcnt == 16'(GAP_CYCLES - 1)) begin
                        if (nblk == 16'd0) begin
                            st   <= S_FIN;
                            done <= 1'b1;
                        end else begin
                            st      <= S_STREAM;
                            rq_done <= 1'b0;
                            bcnt    <= '0;
                            ph      <= 1'b0;
`ifdef SD_SECTOR_CRC16_EN
                            crc     <= '0;
`endif
                        end
                    end else begin
                        gcnt <= gcnt + 16'd1;
                    end
                end
                S_FIN: begin
                    busy <= 1'b0;
                    st   <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule
